// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared op encodings, FSM states and fixed register ids for
//               the sequential execute unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_OR     = 3'd1,
        OP_AND    = 3'd2,
        OP_MOV    = 3'd3,
        OP_MOVABS = 3'd4,
        OP_IMUL   = 3'd5,
        OP_RETQ   = 3'd6,
        OP_NOP    = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HALT = 2'd2
    } fsm_state_t;

    localparam int REG_RAX = 0;
    localparam int REG_RDX = 2;

endpackage

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module      : seq_multiplier
// Description : Fixed-latency unsigned shift-add multiplier, MUL_BITS of b
//               per cycle; done/prod valid combinationally on the last step.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seq_multiplier #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                done,
    output logic [2*XLEN-1:0]   prod
);

    localparam int NSTEPS = XLEN / MUL_BITS;
    localparam int STEP_W = $clog2(NSTEPS + 1);
    localparam logic [STEP_W-1:0] c_last_step = STEP_W'(NSTEPS - 1);

    generate
        if (XLEN % MUL_BITS != 0) begin : g_bad_mul_bits
            $error("seq_multiplier: XLEN must be a multiple of MUL_BITS");
        end
    endgenerate

    logic                r_active;
    logic [STEP_W-1:0]   r_step;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   w_pp;
    logic [2*XLEN-1:0]   w_sum;

    assign w_pp  = r_mcand * {{(2*XLEN-MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};
    assign w_sum = r_acc + w_pp;
    // Final digit is folded in combinationally so the product lands on step NSTEPS.
    assign done  = r_active && (r_step == c_last_step);
    assign prod  = w_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_step   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_step   <= '0;
            r_mcand  <= {{XLEN{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_active) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << MUL_BITS;
            r_mplier <= r_mplier >> MUL_BITS;
            r_step   <= r_step + 1'b1;
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_exec_seq.sv
// ============================================================================
// Module      : alu_exec_seq
// Description : Sequential ALU execute unit with register file, valid/ready
//               intake, iterative IMUL into RDX:RAX, RETQ halt and retire count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 16,
    parameter int MUL_BITS = 8,
    parameter int CNT_W    = 32,
    parameter int RID_W    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_t           in_op,
    input  logic [RID_W-1:0]  in_dst,
    input  logic              in_b_is_imm,
    input  logic [RID_W-1:0]  in_b_reg,
    input  logic [XLEN-1:0]   in_imm,
    output logic              retire_valid,
    output logic [CNT_W-1:0]  retire_count,
    output logic              halted,
    output logic              busy,
    input  logic [RID_W-1:0]  dbg_rid,
    output logic [XLEN-1:0]   dbg_data
);

    localparam logic [RID_W-1:0] c_rax = RID_W'(REG_RAX);
    localparam logic [RID_W-1:0] c_rdx = RID_W'(REG_RDX);

    fsm_state_t          r_state;
    fsm_state_t          w_next_state;
    logic [XLEN-1:0]     r_regs [NREGS];
    logic                r_retire_valid;
    logic [CNT_W-1:0]    r_retire_count;

    logic                w_accept;
    logic [XLEN-1:0]     w_a;
    logic [XLEN-1:0]     w_b;
    logic                w_wr_en;
    logic [XLEN-1:0]     w_wr_data;
    logic                w_retire;
    logic                w_mul_start;
    logic                w_mul_done;
    logic                w_mul_fire;
    logic [2*XLEN-1:0]   w_prod;

    assign w_accept   = in_valid & in_ready;
    assign w_a        = r_regs[in_dst];
    assign w_b        = in_b_is_imm ? in_imm : r_regs[in_b_reg];
    assign w_mul_fire = w_mul_done & (r_state == ST_MUL);

    seq_multiplier #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_mul_start),
        .a       (w_a),
        .b       (w_b),
        .done    (w_mul_done),
        .prod    (w_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && in_op == OP_IMUL) begin
                    w_next_state = ST_MUL;
                end else if (w_accept && in_op == OP_RETQ) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_MUL:  if (w_mul_done) w_next_state = ST_IDLE;
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_IDLE);
        busy     = (r_state == ST_MUL);
        halted   = (r_state == ST_HALT);
    end

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_data   = w_b;
        w_retire    = 1'b0;
        w_mul_start = 1'b0;
        if (w_accept) begin
            w_retire = 1'b1;
            case (in_op)
                OP_ADD:            begin w_wr_en = 1'b1; w_wr_data = w_a + w_b; end
                OP_OR:             begin w_wr_en = 1'b1; w_wr_data = w_a | w_b; end
                OP_AND:            begin w_wr_en = 1'b1; w_wr_data = w_a & w_b; end
                OP_MOV, OP_MOVABS: begin w_wr_en = 1'b1; w_wr_data = w_b;       end
                OP_IMUL:           begin w_retire = 1'b0; w_mul_start = 1'b1;   end
                default:           ;
            endcase
        end else if (w_mul_fire) begin
            w_retire = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[in_dst] <= w_wr_data;
        end else if (w_mul_fire) begin
            r_regs[c_rax] <= w_prod[XLEN-1:0];
            r_regs[c_rdx] <= w_prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retire_valid <= 1'b0;
            r_retire_count <= '0;
        end else begin
            r_retire_valid <= w_retire;
            r_retire_count <= r_retire_count + CNT_W'(w_retire);
        end
    end

    assign retire_valid = r_retire_valid;
    assign retire_count = r_retire_count;
    assign dbg_data     = r_regs[dbg_rid];

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
// ============================================================================
// Module      : tb_alu_exec_seq
// Description : Self-checking bench for alu_exec_seq with a reference register
//               model and a retire-count scoreboard.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_exec_seq;
    import alu_pkg::*;

    localparam int XLEN     = 64;
    localparam int NREGS    = 16;
    localparam int MUL_BITS = 8;
    localparam int CNT_W    = 32;
    localparam int RID_W    = 4;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    alu_op_t           in_op;
    logic [RID_W-1:0]  in_dst;
    logic              in_b_is_imm;
    logic [RID_W-1:0]  in_b_reg;
    logic [XLEN-1:0]   in_imm;
    logic              retire_valid;
    logic [CNT_W-1:0]  retire_count;
    logic              halted;
    logic              busy;
    logic [RID_W-1:0]  dbg_rid;
    logic [XLEN-1:0]   dbg_data;

    alu_exec_seq #(
        .XLEN(XLEN), .NREGS(NREGS), .MUL_BITS(MUL_BITS), .CNT_W(CNT_W), .RID_W(RID_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_dst       (in_dst),
        .in_b_is_imm  (in_b_is_imm),
        .in_b_reg     (in_b_reg),
        .in_imm       (in_imm),
        .retire_valid (retire_valid),
        .retire_count (retire_count),
        .halted       (halted),
        .busy         (busy),
        .dbg_rid      (dbg_rid),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    int                n_total = 0;
    int                n_bad   = 0;
    int                n_retire = 0;
    logic [CNT_W-1:0]  sb_q [$];
    logic [XLEN-1:0]   m_regs [NREGS];
    logic [CNT_W-1:0]  m_count;

    task automatic check_val(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every retire pulse must match the next expected retire count.
    always @(negedge clk) begin
        if (reset_n && retire_valid) begin
            n_retire++;
            if (sb_q.size() == 0) begin
                check_val("retire_unexpected", 64'(retire_valid), 64'd0);
            end else begin
                check_val("retire_count", 64'(retire_count), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_count = '0;
    endtask

    task automatic model_exec(input alu_op_t op, input int dst, input bit isimm, input int breg,
                              input logic [XLEN-1:0] imm);
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [2*XLEN-1:0] p;
        a = m_regs[dst];
        b = isimm ? imm : m_regs[breg];
        case (op)
            OP_ADD:            m_regs[dst] = a + b;
            OP_OR:             m_regs[dst] = a | b;
            OP_AND:            m_regs[dst] = a & b;
            OP_MOV, OP_MOVABS: m_regs[dst] = b;
            OP_IMUL: begin
                p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
                m_regs[REG_RAX] = p[XLEN-1:0];
                m_regs[REG_RDX] = p[2*XLEN-1:XLEN];
            end
            default: ;
        endcase
        m_count = m_count + 1;
        sb_q.push_back(m_count);
    endtask

    task automatic send_op(input alu_op_t op, input int dst, input bit isimm, input int breg,
                           input logic [XLEN-1:0] imm);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_op       = op;
        in_dst      = RID_W'(dst);
        in_b_is_imm = isimm;
        in_b_reg    = RID_W'(breg);
        in_imm      = imm;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            model_exec(op, dst, isimm, breg, imm);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_reg(input int rid);
        dbg_rid = RID_W'(rid);
        #1;
        check_val($sformatf("reg%0d", rid), dbg_data, m_regs[rid]);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (!in_ready && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        clk = 1'b0; reset_n = 1'b0; in_valid = 1'b0; in_op = OP_NOP; in_dst = '0;
        in_b_is_imm = 1'b0; in_b_reg = '0; in_imm = '0; dbg_rid = '0;
        model_reset();
        repeat (3) @(negedge clk);

        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_halted", 64'(halted), 64'd0);
        check_val("rst_retire_valid", 64'(retire_valid), 64'd0);
        check_val("rst_retire_count", 64'(retire_count), 64'd0);
        for (int i = 0; i < NREGS; i++) check_reg(i);
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back dependent adds
        send_op(OP_ADD, 1, 1'b1, 0, 64'd5);
        send_op(OP_ADD, 1, 1'b1, 0, 64'd7);
        repeat (2) @(negedge clk);
        check_reg(1);
        check_val("add_r1_literal", dbg_data, 64'd12);
        check_val("add_retire_pulses", 64'(n_retire), 64'd2);
        check_val("add_retire_count", 64'(retire_count), 64'd2);

        // Wraparound and logic ops, plus a register-sourced operand
        send_op(OP_MOVABS, 3, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        send_op(OP_ADD, 3, 1'b1, 0, 64'd1);
        check_reg(3);
        send_op(OP_OR, 3, 1'b1, 0, 64'hF0);
        check_reg(3);
        send_op(OP_AND, 3, 1'b1, 0, 64'h3C);
        check_reg(3);
        check_val("and_r3_literal", dbg_data, 64'h30);
        send_op(OP_ADD, 4, 1'b0, 1, 64'd0);
        send_op(OP_NOP, 4, 1'b1, 0, 64'hDEAD);
        check_reg(4);

        // IMUL 2^32 * 2^32 with latency measurement
        send_op(OP_MOV, 0, 1'b1, 0, 64'h1_0000_0000);
        send_op(OP_IMUL, 0, 1'b1, 0, 64'h1_0000_0000);
        check_val("imul_busy", 64'(busy), 64'd1);
        wait_ready(n);
        check_val("imul_stall_cycles", 64'(n), 64'(XLEN / MUL_BITS));
        @(negedge clk);
        check_reg(0);
        check_val("imul_rax_literal", dbg_data, 64'd0);
        check_reg(2);
        check_val("imul_rdx_literal", dbg_data, 64'd1);

        // Aliased IMUL with an op offered while busy
        send_op(OP_MOV, 0, 1'b1, 0, 64'd3);
        send_op(OP_IMUL, 0, 1'b0, 0, 64'd0);
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ADD; in_dst = 4'd5; in_b_is_imm = 1'b1; in_imm = 64'd100;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        wait_ready(n);
        check_val("alias_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        check_reg(0);
        check_reg(2);
        check_reg(5);

        // Reset aborts an in-flight multiply
        send_op(OP_MOV, 3, 1'b1, 0, 64'hABCD);
        send_op(OP_IMUL, 3, 1'b1, 0, 64'd7);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        sb_q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        check_val("abort_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check_val("abort_retire_count", 64'(retire_count), 64'd0);
        for (int i = 0; i < 4; i++) check_reg(i);
        send_op(OP_ADD, 1, 1'b1, 0, 64'd9);
        check_reg(1);

        // RETQ halts; later ops are ignored
        send_op(OP_RETQ, 0, 1'b0, 0, 64'd0);
        @(negedge clk);
        check_val("halt_halted", 64'(halted), 64'd1);
        check_val("halt_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_op = OP_ADD; in_dst = 4'd1; in_b_is_imm = 1'b1; in_imm = 64'd1;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        check_reg(1);
        check_val("halt_retire_count", 64'(retire_count), 64'(m_count));
        check_val("halt_still_halted", 64'(halted), 64'd1);
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
